// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state type, the latency-counter type and the address legality check.
package mem_if_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } mem_state_t;

    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned MAX_LATENCY = 15;
    localparam int unsigned CNT_W       = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    // Word aligned and inside the array.
    function automatic logic addr_legal(logic [31:0] addr, int unsigned depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the CPU and the data-memory responder.
interface data_mem_responder_if;

    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  rdata_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output rdata_o, ack_o, err_o, stall_o
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word array: synchronous byte-enabled write, asynchronous read.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [3:0][7:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[waddr_i][b] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one MEM-stage access at a time, stalling the
// pipeline until a fixed-latency ack, with an immediate error ack for illegal addresses.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    data_mem_responder_if.slave mem_io
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    mem_state_t    state_q, state_d;
    cnt_t          cnt_q, cnt_d;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          err_q;
    logic [31:0]   rdata_q, rdata_d;

    logic          accept;
    logic          legal;
    logic [AW-1:0] raddr;
    logic [31:0]   rd_word;
    logic [3:0]    wr_be;

    assign accept = (state_q == StIdle) && mem_io.req_i;
    assign legal  = addr_legal(mem_io.addr_i, DEPTH_WORDS);
    // An L=1 load reads straight from the live address in the accepting cycle.
    assign raddr  = (state_q == StIdle) ? mem_io.addr_i[AW+1:2] : addr_q;

    // Commit is suppressed by a reset arriving in the ack cycle.
    assign wr_be = ((state_q == StResp) && we_q && !err_q && !rst_i) ? be_q : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .be_i    (wr_be),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (raddr),
        .rdata_o (rd_word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= mem_io.we_i;
                addr_q  <= mem_io.addr_i[AW+1:2];
                wdata_q <= mem_io.wdata_i;
                be_q    <= mem_io.be_i;
                err_q   <= !legal;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (mem_io.req_i) begin
                    if (!legal) begin
                        state_d = StResp;
                        rdata_d = '0;
                    end else if (LATENCY <= 1) begin
                        state_d = StResp;
                        if (!mem_io.we_i) rdata_d = rd_word;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = cnt_t'(LATENCY - 1);
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= cnt_t'(1)) begin
                    state_d = StResp;
                    if (!we_q) rdata_d = rd_word;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_io.ack_o   = (state_q == StResp) && !rst_i;
        mem_io.err_o   = (state_q == StResp) && !rst_i && err_q;
        mem_io.stall_o = accept || (state_q == StBusy);
        mem_io.rdata_o = rdata_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected acks, per-DUT monitors pop and compare.
module tb_data_mem_responder;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        logic        chk_data;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q3[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if b3();
    data_mem_responder_if b1();

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
        .clk_i  (clk),
        .rst_i  (rst),
        .mem_io (b3)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .mem_io (b1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input int sel, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        if (sel == 3) begin
            b3.req_i = req; b3.we_i = we; b3.addr_i = addr; b3.wdata_i = wdata; b3.be_i = be;
        end else begin
            b1.req_i = req; b1.we_i = we; b1.addr_i = addr; b1.wdata_i = wdata; b1.be_i = be;
        end
    endtask

    task automatic push(input int sel, input exp_t e);
        if (sel == 3) q3.push_back(e);
        else q1.push_back(e);
    endtask

    // One access: hold req until ack, checking stall every cycle against the expected latency.
    task automatic access(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic exp_err, input logic [31:0] exp_rd, input string nm);
        int   lat;
        int   c0;
        logic acked;
        logic st;
        logic ak;
        exp_t e;
        lat = exp_err ? 1 : ((sel == 3) ? 3 : 1);
        @(posedge clk); #1;
        drive(sel, 1'b1, we, addr, wdata, be);
        c0 = cyc;
        e.cyc = c0 + lat; e.err = exp_err; e.rdata = exp_rd;
        e.chk_data = exp_err || !we; e.name = nm;
        push(sel, e);
        acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            st = (sel == 3) ? b3.stall_o : b1.stall_o;
            ak = (sel == 3) ? b3.ack_o : b1.ack_o;
            chk({nm, " stall"}, {31'd0, st}, {31'd0, (cyc < c0 + lat)});
            if (ak) begin
                acked = 1'b1;
                break;
            end
        end
        if (!acked) begin
            tests++; fails++;
            $display("FAIL %s timeout: no ack within 20 cycles", nm);
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic monitor_check(input exp_t e, input logic err, input logic [31:0] rd);
        chk({e.name, " ack cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.name, " err"}, {31'd0, err}, {31'd0, e.err});
        if (e.chk_data) chk({e.name, " rdata"}, rd, e.rdata);
    endtask

    always @(negedge clk) begin
        if (b3.ack_o) begin
            if (q3.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut3 unexpected ack at cycle %0d", cyc);
            end else begin
                monitor_check(q3.pop_front(), b3.err_o, b3.rdata_o);
            end
        end
    end

    always @(negedge clk) begin
        if (b1.ack_o) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut1 unexpected ack at cycle %0d", cyc);
            end else begin
                monitor_check(q1.pop_front(), b1.err_o, b1.rdata_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        exp_t e;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];
        b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
        b2b_data[0] = 32'h0102_0304; b2b_data[1] = 32'hA5A5_5A5A; b2b_data[2] = 32'h0BAD_F00D;

        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ack", {31'd0, b3.ack_o}, 32'd0);
        chk("reset err", {31'd0, b3.err_o}, 32'd0);
        chk("reset rdata", b3.rdata_o, 32'h0);
        chk("reset stall", {31'd0, b3.stall_o}, 32'd0);
        // Request during reset: stall follows req, but the request is not accepted.
        drive(3, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        #1;
        chk("reset stall=req", {31'd0, b3.stall_o}, 32'd1);
        @(negedge clk);
        chk("reset wins ack", {31'd0, b3.ack_o}, 32'd0);
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        access(3, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, "st 0x10");
        access(3, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, "ld 0x10");
        repeat (2) @(negedge clk);
        chk("rdata hold", b3.rdata_o, 32'hDEAD_BEEF);
        access(3, 1'b1, 32'h10, 32'h0000_1200, 4'b0010, 1'b0, 32'h0, "st byte1");
        access(3, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_12EF, "ld merged");
        access(3, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0, "st be0");
        access(3, 1'b0, 32'h13, 32'h0, 4'h0, 1'b1, 32'h0, "ld misalign");
        access(3, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, 32'h0, "ld oor");
        access(3, 1'b1, 32'h12, 32'hAAAA_AAAA, 4'hF, 1'b1, 32'h0, "st misalign");
        access(3, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEAD_12EF, "ld unchanged");
        access(3, 1'b1, 32'h3FC, 32'h1357_9BDF, 4'hF, 1'b0, 32'h0, "st top");
        access(3, 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, 32'h1357_9BDF, "ld top");
        access(3, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, "st 0x20");

        // Reset in BUSY: abandon the store.
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 32'h20, 32'h1111_1111, 4'hF);
        c0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("rst busy ack", {31'd0, b3.ack_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst busy no ack", {31'd0, b3.ack_o}, 32'd0);
        end
        access(3, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, "ld after busy rst");

        // Reset in RESP: no ack and no commit.
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 32'h20, 32'h2222_2222, 4'hF);
        c0 = cyc;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("resp state reached", 32'(cyc), 32'(c0 + 3));
        rst = 1'b1;
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("rst resp ack", {31'd0, b3.ack_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        access(3, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, "ld after resp rst");

        // LATENCY=1 instance.
        for (int i = 0; i < 3; i++) begin
            access(1, 1'b1, b2b_addr[i], b2b_data[i], 4'hF, 1'b0, 32'h0, "l1 st");
        end
        access(1, 1'b0, 32'h404, 32'h0, 4'h0, 1'b1, 32'h0, "l1 ld oor");

        // Back-to-back loads with req held high; the next address is set in the ack cycle.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, b2b_addr[0], 32'h0, 4'h0);
        e.cyc = cyc + 1; e.err = 1'b0; e.rdata = b2b_data[0]; e.chk_data = 1'b1;
        e.name = "l1 b2b 0";
        q1.push_back(e);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k < 2) begin
                drive(1, 1'b1, 1'b0, b2b_addr[k+1], 32'h0, 4'h0);
                e.cyc = cyc + 2; e.rdata = b2b_data[k+1];
                e.name = (k == 0) ? "l1 b2b 1" : "l1 b2b 2";
                q1.push_back(e);
                @(posedge clk); #1;
            end else begin
                drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
        end

        repeat (6) @(posedge clk);
        chk("dut3 pending acks", 32'(q3.size()), 32'd0);
        chk("dut1 pending acks", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder serving the CPU MEM-stage load/store requests. It accepts one request at a time over a req/ack handshake and holds a word-addressed storage array. It drives `stall_o` so the pipeline freezes until the access completes, then returns load data or commits store data with byte enables. It sits between EXMEM/MEMWB and the data storage, replacing the single-cycle data memory.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- `LATENCY`, 3: cycles from request acceptance to `ack_o`; legal range 1..15.

- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in 1: access request from the MEM stage, level, held until `ack_o`.
- `we_i` in 1: 1 = store, 0 = load; sampled at acceptance.
- `addr_i` in 32: byte address; sampled at acceptance.
- `wdata_i` in 32: store data; sampled at acceptance.
- `be_i` in 4: store byte enables, bit n covers `wdata_i[8n+7:8n]`; ignored for loads.
- `rdata_o` out 32: load data, valid in the `ack_o` cycle, held afterwards.
- `ack_o` out 1: one-cycle completion pulse.
- `err_o` out 1: qualifies `ack_o`; access rejected.
- `stall_o` out 1: pipeline freeze request to PC, IFID, IDEX, EXMEM, MEMWB.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE with `req_i`=1: latch `we`, `addr`, `wdata` and `be`. If the request is legal, go to BUSY with `cnt` = LATENCY-1. If it is illegal, go to RESP with the error flag set.
- LATENCY=1: an accepted legal request goes straight to RESP.
- BUSY: `cnt` decrements each cycle. At `cnt`=1 go to RESP.
- RESP: assert `ack_o`.
  - Load: `rdata_o` = `mem[addr[31:2]]`.
  - Store: bytes with `be`=1 are written at the end of the RESP cycle. Other bytes are unchanged. `be`=0000 still acks, with no change.
  - Next state is always IDLE.
- Illegal request: `addr[1:0]`≠0, or `addr[31:2]` ≥ DEPTH_WORDS. Response: `ack_o`=1 and `err_o`=1, `rdata_o`=0, no write. Latency is 1 cycle regardless of LATENCY.
- `stall_o` = (state==IDLE & `req_i`) | (state==BUSY). It is 0 in RESP so the pipeline advances in the ack cycle.
- The requester must drop or replace `req_i` the cycle after `ack_o`. A `req_i` still high in IDLE is treated as a new request.
- Changes to `we_i`, `addr_i`, `wdata_i` or `be_i` in BUSY or RESP are ignored.
- Storage contents are not reset. Load-after-store to the same word returns the stored value.

## Timing
- Reset values: state IDLE, `cnt` 0, `ack_o` 0, `err_o` 0, `rdata_o` 0. `stall_o` = `req_i`, because it is combinational from IDLE.
- Legal request accepted at cycle T → `ack_o` at T+LATENCY, `stall_o` high from T to T+LATENCY-1.
- Illegal request accepted at T → `ack_o`/`err_o` at T+1.
- Back-to-back requests: ack at T+L, next acceptance no earlier than T+L+1.
- `rst_i` asserted in BUSY or RESP: the access is abandoned and no write occurs, even if RESP was reached. The FSM returns to IDLE next cycle and no `ack_o` is issued.
- `rst_i` and `req_i` in the same cycle: reset wins and the request is not accepted.

## Structure
- Package `mem_if_pkg`:
  - State enum `mem_state_t` {IDLE, BUSY, RESP}.
  - `WORD_BYTES`=4.
  - `MAX_LATENCY`=15.
  - Counter width of 4 bits.
- Sub-module `dmem_array`: single-port, synchronous-write, asynchronous-read word array with per-byte write enable, parameterised by DEPTH_WORDS.
- The FSM, latch registers and range check live in `data_mem_responder`.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 with `be`=1111, L=3; req at T → `stall_o` 1 for T..T+2, `ack_o` at T+3, `err_o`=0.
- Load 0x10 after that store → `ack_o` at T+3 with `rdata_o`=0xDEADBEEF. `rdata_o` holds the value after `req_i` drops.
- Store 0x00001200 to 0x10 with `be`=0010, then load 0x10 → 0xDEAD12EF.
- Load from 0x13 (misaligned), and separately from 0x400 (out of range, DEPTH_WORDS=256) → `ack_o`=`err_o`=1 at T+1, `rdata_o`=0, memory unchanged.
- Store 0x11111111 to 0x20, `rst_i` pulsed at T+2 → no `ack_o`. A later load of 0x20 returns the prior contents.
- LATENCY=1, three back-to-back loads → each acked one cycle after acceptance with the correct data, and no request is accepted twice.
